rr_pri_arbiter: RTL

Round-robin arbiter that shares one resource between 16 requesters, typically a board-level peripheral driven from SW/KEY-derived request lines. It is built around a rotating priority encoder: the requester after the last winner has the highest priority. The grant is registered and held until the owner releases it, or until an optional hold limit expires. It sits between the request sources and the shared resource's select and enable inputs.

---
 rtl/rr_pri_arbiter_pkg.sv | 33 +++
 rtl/rr_pri_arbiter_if.sv | 32 +++
 rtl/rr_pri_arbiter_enc.sv | 52 +++++
 rtl/rr_pri_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/rr_pri_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared constants, FSM state type and small helpers for the round-robin
// arbiter (rr_pri_arbiter) and its rotating priority encoder (rr_pri_enc).
// -----------------------------------------------------------------------------
package rr_arb_pkg;

    // Number of requesters and width of a requester index (log2(N)).
    localparam int N   = 16;
    localparam int IDW = 4;

    // The last register resets to N-1 so the first search starts at index 0.
    localparam logic [IDW-1:0] LAST_RST = 4'hF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index addition modulo N; wrap is free because N is a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                                input logic [IDW-1:0] b);
        return a + b;
    endfunction

    // Binary index to one-hot vector.
    function automatic logic [N-1:0] idx_to_onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] one_s;
        one_s = {{(N-1){1'b0}}, 1'b1};
        return one_s << idx;
    endfunction

endpackage

// File: rtl/rr_pri_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_pri_arbiter_if
// Request/grant bundle between the request sources and the arbiter.
//   enable    : permits new grants
//   req[N]    : request vector, bit i held high while requester i wants/uses
//   gnt[N]    : one-hot registered grant
//   gnt_id    : binary owner index (valid only with gnt_valid)
//   gnt_valid : high while a grant is held
//   timeout   : one-cycle pulse on a forced release
// Modports: master = request side, slave = arbiter.
// -----------------------------------------------------------------------------
interface rr_pri_arbiter_if;
    import rr_arb_pkg::*;

    logic           enable;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;

    modport master (
        output enable, req,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  enable, req,
        output gnt, gnt_id, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_pri_arbiter_enc.sv
// -----------------------------------------------------------------------------
// rr_pri_enc
// Purely combinational rotating priority encoder. The requester at index
// last+1 has highest priority, searching upward and wrapping N-1 -> 0.
// Built as: rotate req so index last+1 lands at bit 0, fixed lowest-first
// priority encode, then add last+1 back (mod N).
// With last = N-1 it degenerates to a plain lowest-index-first encoder.
//   req[N]   : request vector
//   last[IDW]: index of the previous winner
//   any      : at least one request present
//   idx[IDW] : winning index (meaningful only when any = 1)
// -----------------------------------------------------------------------------
module rr_pri_enc
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] start_s;
    logic [N-1:0]   rot_s;
    logic [IDW-1:0] off_s;

    assign start_s = wrap_add(last, 4'd1);

    // Rotate so that requester start_s appears at bit 0.
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < N; i++) begin
            rot_s[i] = req[wrap_add(IDW'(i), start_s)];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        off_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = IDW'(i);
            end else begin
                off_s = off_s;
            end
        end
    end

    assign any = |rot_s;
    assign idx = wrap_add(off_s, start_s);

endmodule

// File: rtl/rr_pri_arbiter.sv
// -----------------------------------------------------------------------------
// rr_pri_arbiter
// Round-robin arbiter for 16 requesters. A registered grant is issued from
// IDLE when enable=1 and any request is present; the requester after the last
// winner has priority. The grant is held until the owner drops its request
// (or, optionally, until the hold limit expires), then at least one IDLE cycle
// follows before the next grant.
//   clock          : rising-edge clock
//   reset          : asynchronous, active-high reset
//   bus (slave)    : enable, req in; gnt, gnt_id, gnt_valid, timeout out
// Parameter MAX_HOLD: maximum cycles in GRANT (timeout build only).
// Optional feature macro: RR_PRI_ARBITER_TIMEOUT_EN -- builds the hold
// counter and forced release with a one-cycle timeout pulse; without it the
// grant has no limit and timeout is constant 0.
// -----------------------------------------------------------------------------
module rr_pri_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  logic              clock,
    input  logic              reset,
    rr_pri_arbiter_if.slave   bus
);

    arb_state_t     state_r, state_n_s;
    logic [N-1:0]   gnt_r, gnt_n_s;
    logic [IDW-1:0] gnt_id_r, gnt_id_n_s;
    logic           gnt_valid_r, gnt_valid_n_s;
    logic           timeout_r, timeout_n_s;
    logic [IDW-1:0] last_r, last_n_s;

    logic           any_s;
    logic [IDW-1:0] win_idx_s;
    logic           hold_limit_s;

    rr_pri_enc u_enc (
        .req  (bus.req),
        .last (last_r),
        .any  (any_s),
        .idx  (win_idx_s)
    );

`ifdef RR_PRI_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt_r;

    // Cycles spent in GRANT; sits at zero in IDLE so entry starts from 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt_r <= '0;
        end else if (state_r == IDLE) begin
            hold_cnt_r <= '0;
        end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end
    end

    assign hold_limit_s = (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
`else
    assign hold_limit_s = 1'b0;
`endif

    // FSM and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            gnt_id_r    <= '0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            last_r      <= LAST_RST;
        end else begin
            state_r     <= state_n_s;
            gnt_r       <= gnt_n_s;
            gnt_id_r    <= gnt_id_n_s;
            gnt_valid_r <= gnt_valid_n_s;
            timeout_r   <= timeout_n_s;
            last_r      <= last_n_s;
        end
    end

    // Next-state and next-output logic. A normal release is checked before
    // the hold limit so a simultaneous release never pulses timeout.
    always_comb begin
        state_n_s     = state_r;
        gnt_n_s       = gnt_r;
        gnt_id_n_s    = gnt_id_r;
        gnt_valid_n_s = gnt_valid_r;
        timeout_n_s   = 1'b0;
        last_n_s      = last_r;
        case (state_r)
            IDLE: begin
                if (bus.enable && any_s) begin
                    state_n_s     = GRANT;
                    gnt_n_s       = idx_to_onehot(win_idx_s);
                    gnt_id_n_s    = win_idx_s;
                    gnt_valid_n_s = 1'b1;
                end else begin
                    state_n_s     = IDLE;
                end
            end
            GRANT: begin
                if (!bus.req[gnt_id_r]) begin
                    state_n_s     = IDLE;
                    gnt_n_s       = '0;
                    gnt_id_n_s    = '0;
                    gnt_valid_n_s = 1'b0;
                    last_n_s      = gnt_id_r;
                end else if (hold_limit_s) begin
                    state_n_s     = IDLE;
                    gnt_n_s       = '0;
                    gnt_id_n_s    = '0;
                    gnt_valid_n_s = 1'b0;
                    last_n_s      = gnt_id_r;
                    timeout_n_s   = 1'b1;
                end else begin
                    state_n_s     = GRANT;
                end
            end
            default: begin
                state_n_s     = IDLE;
                gnt_n_s       = '0;
                gnt_id_n_s    = '0;
                gnt_valid_n_s = 1'b0;
                last_n_s      = LAST_RST;
            end
        endcase
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.timeout   = timeout_r;

endmodule
